// File: rtl/stream_demultiplexer.sv
// Routes one valid/ready word stream to one of CHANNELS registered output slots, chosen per word by sel.
// Optional saturating dropped-word counter enabled by STREAM_DEMUX_DROP_COUNT_EN.
module stream_demultiplexer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  output logic [CHANNELS-1:0]           out_valid,
  input  logic [CHANNELS-1:0]           out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_bus,
  output logic                          drop_pulse,
  output logic [15:0]                   drop_count
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int NPAD  = 1 << SEL_W;
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  // Handshake: a word moves when valid and ready are both high at a rising edge;
  // ready never depends on the same interface's valid.
  logic [CHANNELS-1:0] valid_q;
  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic                drop_pulse_q;

  logic [NPAD-1:0]     valid_pad;
  logic [NPAD-1:0]     ready_pad;
  logic                in_range;
  logic                accept;
  logic                drop_d;
  logic [CHANNELS-1:0] load_d;

  // Pad to a power of two so an out-of-range sel never indexes past the vector.
  always_comb begin
    valid_pad = '0;
    ready_pad = '0;
    valid_pad[CHANNELS-1:0] = valid_q;
    ready_pad[CHANNELS-1:0] = out_ready;
  end

  assign in_range = ({1'b0, sel} < CH_LIMIT);
  assign in_ready = in_range ? (!valid_pad[sel] || ready_pad[sel]) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign drop_d   = accept && !in_range;

  always_comb begin
    load_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load_d[c] = accept && in_range && (sel == SEL_W'(c));
    end
  end

  // Each channel is EMPTY (valid_q=0) or FULL (valid_q=1); load wins over pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      drop_pulse_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        data_q[c] <= '0;
      end
    end else begin
      drop_pulse_q <= drop_d;
      for (int c = 0; c < CHANNELS; c++) begin
        if (load_d[c]) begin
          valid_q[c] <= 1'b1;
          data_q[c]  <= in_data;
        end else if (out_ready[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // Channel 0 lands in the most-significant slice, matching the multiplexer's bus.
  always_comb begin
    out_bus = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_bus[(CHANNELS-1-c)*WIDTH +: WIDTH] = data_q[c];
    end
  end

  assign out_valid  = valid_q;
  assign drop_pulse = drop_pulse_q;

`ifdef STREAM_DEMUX_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule
